sound_event_arbiter: RTL and testbench

- Shares the single square-wave tone generator inside the sound path among three game event requesters: dino jump, score milestone and collision.
- Latches one-cycle event pulses, grants them by fixed priority (hit > milestone > jump) and sequences note/duration/gap timing.
- Drives the tone generator's divisor and enable.
- Sits between the object/score logic and the audio serializer, on the 100 MHz system clock.

---
 rtl/sound_event_arbiter.sv | 179 +++++++++++++++++
 tb/tb_sound_event_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_event_arbiter.sv
// Shares one square-wave tone generator among jump, milestone and collision sounds.
// Fixed priority hit > mile > jump; a hit cuts off any other sound, or restarts itself.
module sound_event_arbiter #(
    parameter int          TICK_DIV   = 100000,
    parameter int          JUMP_MS    = 100,
    parameter int          MILE_MS    = 80,
    parameter int          HIT_MS     = 300,
    parameter int          GAP_MS     = 20,
    parameter logic [21:0] JUMP_NOTE  = 22'd113636,
    parameter logic [21:0] MILE_NOTE1 = 22'd75843,
    parameter logic [21:0] MILE_NOTE2 = 22'd56818,
    parameter logic [21:0] HIT_NOTE   = 22'd227272
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mute,
    input  logic        ev_jump,
    input  logic        ev_mile,
    input  logic        ev_hit,
    output logic        tone_en,
    output logic [21:0] note_div,
    output logic [1:0]  active_src,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_JUMP = 2'd1;
    localparam logic [1:0] SRC_MILE = 2'd2;
    localparam logic [1:0] SRC_HIT  = 2'd3;

    localparam int MAX_JM = (JUMP_MS > MILE_MS) ? JUMP_MS : MILE_MS;
    localparam int MAX_HG = (HIT_MS > GAP_MS) ? HIT_MS : GAP_MS;
    localparam int MAX_MS = (MAX_JM > MAX_HG) ? MAX_JM : MAX_HG;
    localparam int DUR_W  = $clog2(MAX_MS + 1);
    localparam int TICK_W = $clog2(TICK_DIV);

    logic [1:0]        state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [DUR_W-1:0]  dur_cnt;
    logic              note_end;
    logic              mile_second;
    logic              jump_p;
    logic              mile_p;
    logic              hit_p;
    logic              grant_jump;
    logic              grant_mile;
    logic              grant_hit;
    logic              any_grant;
    logic [1:0]        grant_src;

    function automatic logic [DUR_W-1:0] src_ms(input logic [1:0] src);
        case (src)
            SRC_JUMP: src_ms = DUR_W'(JUMP_MS);
            SRC_MILE: src_ms = DUR_W'(MILE_MS);
            SRC_HIT:  src_ms = DUR_W'(HIT_MS);
            default:  src_ms = DUR_W'(GAP_MS);
        endcase
    endfunction

    function automatic logic [21:0] src_note(input logic [1:0] src);
        case (src)
            SRC_JUMP: src_note = JUMP_NOTE;
            SRC_MILE: src_note = MILE_NOTE1;
            SRC_HIT:  src_note = HIT_NOTE;
            default:  src_note = 22'd0;
        endcase
    endfunction

    // Tick counter free-runs so that grants never realign the ms timebase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));
    assign note_end = tick && (dur_cnt == DUR_W'(1));

    // From PLAY only a hit may be granted: preempting jump/mile, or restarting itself.
    always_comb begin
        grant_hit  = 1'b0;
        grant_mile = 1'b0;
        grant_jump = 1'b0;
        if (state == IDLE) begin
            grant_hit  = hit_p;
            grant_mile = !hit_p && mile_p;
            grant_jump = !hit_p && !mile_p && jump_p;
        end else if (state == PLAY) begin
            grant_hit  = hit_p;
        end
        any_grant = grant_hit || grant_mile || grant_jump;
        grant_src = grant_hit  ? SRC_HIT  :
                    grant_mile ? SRC_MILE :
                    grant_jump ? SRC_JUMP : SRC_NONE;
    end

    // A pulse arriving in the same cycle as its own grant keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jump_p <= 1'b0;
            mile_p <= 1'b0;
            hit_p  <= 1'b0;
        end else begin
            jump_p <= ev_jump | (jump_p & ~grant_jump);
            mile_p <= ev_mile | (mile_p & ~grant_mile);
            hit_p  <= ev_hit  | (hit_p  & ~grant_hit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            dur_cnt     <= '0;
            mile_second <= 1'b0;
            tone_en     <= 1'b0;
            note_div    <= 22'd0;
            active_src  <= SRC_NONE;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_grant) begin
                        state       <= PLAY;
                        active_src  <= grant_src;
                        note_div    <= src_note(grant_src);
                        dur_cnt     <= src_ms(grant_src);
                        mile_second <= 1'b0;
                        tone_en     <= ~mute;
                        busy        <= 1'b1;
                    end
                end
                PLAY: begin
                    tone_en <= ~mute;
                    if (grant_hit) begin
                        active_src  <= SRC_HIT;
                        note_div    <= HIT_NOTE;
                        dur_cnt     <= DUR_W'(HIT_MS);
                        mile_second <= 1'b0;
                    end else if (note_end) begin
                        if (active_src == SRC_MILE && !mile_second) begin
                            note_div    <= MILE_NOTE2;
                            dur_cnt     <= DUR_W'(MILE_MS);
                            mile_second <= 1'b1;
                        end else begin
                            state      <= GAP;
                            dur_cnt    <= DUR_W'(GAP_MS);
                            tone_en    <= 1'b0;
                            note_div   <= 22'd0;
                            active_src <= SRC_NONE;
                        end
                    end else if (tick) begin
                        dur_cnt <= dur_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (note_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tick) begin
                        dur_cnt <= dur_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sound_event_arbiter.sv
// Scoreboard bench: each output change is matched against a queued expected state,
// with the segment duration and the exact appearance cycle checked where known.
module tb_sound_event_arbiter;

    localparam logic [21:0] JN  = 22'd113636;
    localparam logic [21:0] MN1 = 22'd75843;
    localparam logic [21:0] MN2 = 22'd56818;
    localparam logic [21:0] HN  = 22'd227272;

    logic        clk;
    logic        rst;
    logic        mute;
    logic        ev_jump;
    logic        ev_mile;
    logic        ev_hit;
    logic        tone_en;
    logic [21:0] note_div;
    logic [1:0]  active_src;
    logic        busy;

    sound_event_arbiter #(
        .TICK_DIV(4), .JUMP_MS(3), .MILE_MS(2), .HIT_MS(5), .GAP_MS(2)
    ) dut (
        .clk(clk), .rst(rst), .mute(mute),
        .ev_jump(ev_jump), .ev_mile(ev_mile), .ev_hit(ev_hit),
        .tone_en(tone_en), .note_div(note_div),
        .active_src(active_src), .busy(busy)
    );

    typedef struct {
        string       tag;
        logic        tone;
        logic [21:0] div;
        logic [1:0]  src;
        logic        bsy;
        int          min_len;
        int          max_len;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at cycle %0d, required to finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic t, input logic [21:0] d,
                        input logic [1:0] s, input logic b,
                        input int mn, input int mx, input int lat);
        exp_t e;
        e.tag = tag; e.tone = t; e.div = d; e.src = s; e.bsy = b;
        e.min_len = mn; e.max_len = mx;
        e.at_cyc = (lat < 0) ? -1 : cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic j, input logic m, input logic h);
        ev_jump = j; ev_mile = m; ev_hit = h;
        @(posedge clk); #1;
        ev_jump = 1'b0; ev_mile = 1'b0; ev_hit = 1'b0;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!busy) begin
            miscompares++;
            $display("FAIL busy_timeout: busy=%0b after %0d cycles, required 1", busy, n);
        end
    endtask

    task automatic wait_idle();
        int quiet = 0;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 400 && quiet < 6; i++) begin
            @(posedge clk); #1;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 6) begin
            miscompares++;
            $display("FAIL idle_timeout: busy still 1 at cycle %0d, required 0", cyc);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Monitor: every change of the output tuple is one presented response.
    logic [25:0] last_obs;
    bit          have_last = 0;
    int          seg_start = 0;
    int          seg_min = 0;
    int          seg_max = 0;
    string       seg_tag = "";

    always @(negedge clk) begin
        logic [25:0] obs;
        exp_t e;
        obs = {tone_en, note_div, active_src, busy};
        if (!have_last || obs !== last_obs) begin
            if (have_last && seg_max > 0) begin
                vectors++;
                if (cyc - seg_start < seg_min || cyc - seg_start > seg_max) begin
                    miscompares++;
                    $display("FAIL %s_len: lasted %0d cycles, required %0d..%0d",
                             seg_tag, cyc - seg_start, seg_min, seg_max);
                end
            end
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_output at cycle %0d: tone=%0b div=%0d src=%b busy=%0b, required no change",
                         cyc, tone_en, note_div, active_src, busy);
                seg_min = 0; seg_max = 0; seg_tag = "unexpected";
            end else begin
                e = exp_q.pop_front();
                if (obs !== {e.tone, e.div, e.src, e.bsy}) begin
                    miscompares++;
                    $display("FAIL %s: got tone=%0b div=%0d src=%b busy=%0b, required tone=%0b div=%0d src=%b busy=%0b",
                             e.tag, tone_en, note_div, active_src, busy, e.tone, e.div, e.src, e.bsy);
                end
                if (e.at_cyc >= 0) begin
                    vectors++;
                    if (cyc != e.at_cyc) begin
                        miscompares++;
                        $display("FAIL %s_cycle: appeared at cycle %0d, required %0d", e.tag, cyc, e.at_cyc);
                    end
                end
                seg_min = e.min_len; seg_max = e.max_len; seg_tag = e.tag;
            end
            have_last = 1;
            last_obs  = obs;
            seg_start = cyc;
        end
    end

    initial begin
        rst = 1'b1; mute = 1'b0;
        ev_jump = 1'b0; ev_mile = 1'b0; ev_hit = 1'b0;
        push("reset", 0, 22'd0, 2'b00, 0, 0, 0, -1);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // Single jump
        push("jump",      1, JN, 2'b01, 1, 9, 12, 2);
        push("jump_gap",  0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("jump_idle", 0, 22'd0, 2'b00, 0, 0, 0, -1);
        pulse(1, 0, 0);
        wait_idle();

        // Milestone: two notes back to back
        push("mile1",     1, MN1, 2'b10, 1, 5, 8, 2);
        push("mile2",     1, MN2, 2'b10, 1, 8, 8, -1);
        push("mile_gap",  0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("mile_idle", 0, 22'd0, 2'b00, 0, 0, 0, -1);
        pulse(0, 1, 0);
        wait_idle();

        // Hit preempts jump four cycles into the tone
        push("pre_jump", 1, JN, 2'b01, 1, 5, 5, 2);
        pulse(1, 0, 0);
        wait_busy();
        repeat (3) @(posedge clk);
        #1;
        push("pre_hit",  1, HN, 2'b11, 1, 17, 20, 2);
        push("pre_gap",  0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("pre_idle", 0, 22'd0, 2'b00, 0, 0, 0, -1);
        pulse(0, 0, 1);
        wait_idle();

        // Mile during jump waits for the jump to finish
        push("jm_jump",   1, JN, 2'b01, 1, 9, 12, 2);
        push("jm_gap1",   0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("jm_idle1",  0, 22'd0, 2'b00, 0, 1, 1, -1);
        push("jm_mile1",  1, MN1, 2'b10, 1, 5, 8, -1);
        push("jm_mile2",  1, MN2, 2'b10, 1, 8, 8, -1);
        push("jm_gap2",   0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("jm_idle2",  0, 22'd0, 2'b00, 0, 0, 0, -1);
        pulse(1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        pulse(0, 1, 0);
        wait_idle();

        // All three in one cycle
        push("all_hit",   1, HN, 2'b11, 1, 17, 20, 2);
        push("all_gap1",  0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("all_idle1", 0, 22'd0, 2'b00, 0, 1, 1, -1);
        push("all_mile1", 1, MN1, 2'b10, 1, 5, 8, -1);
        push("all_mile2", 1, MN2, 2'b10, 1, 8, 8, -1);
        push("all_gap2",  0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("all_idle2", 0, 22'd0, 2'b00, 0, 1, 1, -1);
        push("all_jump",  1, JN, 2'b01, 1, 9, 12, -1);
        push("all_gap3",  0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("all_idle3", 0, 22'd0, 2'b00, 0, 0, 0, -1);
        pulse(1, 1, 1);
        wait_idle();

        // Second hit while hit plays restarts the duration
        push("rs_hit",  1, HN, 2'b11, 1, 26, 29, 2);
        push("rs_gap",  0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("rs_idle", 0, 22'd0, 2'b00, 0, 0, 0, -1);
        pulse(0, 0, 1);
        wait_busy();
        repeat (7) @(posedge clk);
        #1;
        pulse(0, 0, 1);
        wait_idle();

        // Muted hit, unmuted mid-tone
        mute = 1'b1;
        push("mute_hit", 0, HN, 2'b11, 1, 6, 6, 2);
        pulse(0, 0, 1);
        wait_busy();
        repeat (5) @(posedge clk);
        #1;
        push("unmute_hit", 1, HN, 2'b11, 1, 11, 14, 1);
        push("mute_gap",   0, 22'd0, 2'b00, 1, 5, 8, -1);
        push("mute_idle",  0, 22'd0, 2'b00, 0, 0, 0, -1);
        mute = 1'b0;
        wait_idle();

        // Async reset mid-hit drops the queued jump
        push("rst_hit", 1, HN, 2'b11, 1, 5, 5, 2);
        pulse(0, 0, 1);
        wait_busy();
        repeat (2) @(posedge clk);
        #1;
        pulse(1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        push("rst_clear", 0, 22'd0, 2'b00, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s_missing: output never presented, required tone=%0b div=%0d src=%b busy=%0b",
                     e.tag, e.tone, e.div, e.src, e.bsy);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
